// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory read/write port among NREQ requesters.
// One transaction outstanding at a time; a timeout aborts a transaction whose valid never arrives.
module mem_port_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned AW      = 11,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] adrs,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [NREQ-1:0]    err,
  output logic [DW-1:0]      rdata,
  output logic               busy,
  output logic [AW-1:0]      mem_adrs,
  output logic [DW-1:0]      mem_wdata,
  output logic               mem_w_en,
  output logic               mem_r_en,
  input  logic [DW-1:0]      mem_rdata,
  input  logic               mem_r_valid,
  input  logic               mem_w_valid
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t          state_q, state_nxt;
  logic [IW-1:0]   ptr_q, ptr_nxt;
  logic            op_we_q, op_we_nxt;
  logic [CW-1:0]   cnt_q, cnt_nxt;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   cand;
  logic [NREQ-1:0] cur_onehot;

  logic [NREQ-1:0] gnt_nxt, done_nxt, err_nxt;
  logic [DW-1:0]   rdata_nxt, mem_wdata_nxt;
  logic [AW-1:0]   mem_adrs_nxt;
  logic            busy_nxt, w_en_nxt, r_en_nxt;

  // Scan downward so the nearest set bit after ptr is the last (winning) assignment.
  always_comb begin
    sel  = ptr_q;
    cand = ptr_q;
    for (int unsigned i = NREQ; i >= 1; i--) begin
      cand = IW'((32'(ptr_q) + i) % NREQ);
      if (req[cand]) sel = cand;
    end
  end

  assign cur_onehot = NREQ'(1) << ptr_q;

  // Next-state and registered-output computation.
  always_comb begin
    state_nxt     = state_q;
    ptr_nxt       = ptr_q;
    op_we_nxt     = op_we_q;
    cnt_nxt       = cnt_q;
    gnt_nxt       = '0;
    done_nxt      = '0;
    err_nxt       = '0;
    rdata_nxt     = rdata;
    busy_nxt      = busy;
    mem_adrs_nxt  = mem_adrs;
    mem_wdata_nxt = mem_wdata;
    w_en_nxt      = 1'b0;
    r_en_nxt      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          ptr_nxt       = sel;
          op_we_nxt     = we[sel];
          mem_adrs_nxt  = adrs[32'(sel) * AW +: AW];
          mem_wdata_nxt = wdata[32'(sel) * DW +: DW];
          gnt_nxt       = NREQ'(1) << sel;
          w_en_nxt      = we[sel];
          r_en_nxt      = !we[sel];
          busy_nxt      = 1'b1;
          state_nxt     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = S_WAIT;
      end

      S_WAIT: begin
        // Only the valid matching the latched operation completes the transaction.
        if (op_we_q ? mem_w_valid : mem_r_valid) begin
          done_nxt  = cur_onehot;
          if (!op_we_q) rdata_nxt = mem_rdata;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_nxt   = cur_onehot;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      ptr_q     <= IW'(NREQ - 1);
      op_we_q   <= 1'b0;
      cnt_q     <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_adrs  <= '0;
      mem_wdata <= '0;
      mem_w_en  <= 1'b0;
      mem_r_en  <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      ptr_q     <= ptr_nxt;
      op_we_q   <= op_we_nxt;
      cnt_q     <= cnt_nxt;
      gnt       <= gnt_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      rdata     <= rdata_nxt;
      busy      <= busy_nxt;
      mem_adrs  <= mem_adrs_nxt;
      mem_wdata <= mem_wdata_nxt;
      mem_w_en  <= w_en_nxt;
      mem_r_en  <= r_en_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory environment with configurable valid latency,
// plus a transaction-level reference (rotation pick, shadow memory, last-read register).
module tb_mem_port_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned AW      = 11;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned MSZ     = 2 ** AW;

  logic               clk = 1'b0;
  logic               resetn;
  logic [NREQ-1:0]    req, we;
  logic [NREQ*AW-1:0] adrs;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt, done, err;
  logic [DW-1:0]      rdata, mem_wdata, mem_rdata;
  logic               busy, mem_w_en, mem_r_en, mem_r_valid, mem_w_valid;
  logic [AW-1:0]      mem_adrs;

  mem_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn), .req(req), .we(we), .adrs(adrs), .wdata(wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy),
    .mem_adrs(mem_adrs), .mem_wdata(mem_wdata), .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
    .mem_rdata(mem_rdata), .mem_r_valid(mem_r_valid), .mem_w_valid(mem_w_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] seed_word(input int a);
    return (DW'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory environment: registered valids, read latency r_delay (0 = never respond).
  logic [DW-1:0] env_mem [MSZ];
  bit            env_ready = 1'b0;
  int            r_delay = 1;
  int            r_cnt = 0;
  logic [AW-1:0] r_addr = '0;
  logic          r_valid_q = 1'b0, w_valid_q = 1'b0;
  logic [DW-1:0] rdata_q = '0;
  logic          inj_r = 1'b0, inj_w = 1'b0;
  logic [DW-1:0] inj_data = '0;
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_a = '0;
  logic [DW-1:0] poke_d = '0;

  assign mem_r_valid = r_valid_q | inj_r;
  assign mem_rdata   = inj_r ? inj_data : rdata_q;
  assign mem_w_valid = w_valid_q | inj_w;

  always @(posedge clk) begin
    if (!env_ready) begin
      for (int a = 0; a < int'(MSZ); a++) env_mem[a] <= seed_word(a);
      env_ready <= 1'b1;
    end else begin
      r_valid_q <= 1'b0;
      w_valid_q <= (mem_w_en === 1'b1);
      if (poke_en) env_mem[poke_a] <= poke_d;
      if (mem_w_en === 1'b1) env_mem[mem_adrs] <= mem_wdata;
      if (mem_r_en === 1'b1) begin
        if (r_delay == 1) begin
          r_valid_q <= 1'b1;
          rdata_q   <= env_mem[mem_adrs];
        end else if (r_delay > 1) begin
          r_cnt  <= r_delay - 1;
          r_addr <= mem_adrs;
        end
      end else if (r_cnt == 1) begin
        r_valid_q <= 1'b1;
        rdata_q   <= env_mem[r_addr];
        r_cnt     <= 0;
      end else if (r_cnt > 1) begin
        r_cnt <= r_cnt - 1;
      end
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [MSZ];
  int            ref_ptr;
  logic [DW-1:0] ref_rdata;
  int            n_tests = 0;
  int            n_fail  = 0;

  function automatic int rr_pick(input int p, input logic [NREQ-1:0] m);
    for (int off = 1; off <= int'(NREQ); off++)
      if (m[(p + off) % NREQ]) return (p + off) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int k);
    logic [NREQ-1:0] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  task automatic set_slot(input int k, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[k] = w;
    adrs[k*AW +: AW] = a;
    wdata[k*DW +: DW] = d;
  endtask

  // Per-transaction observations.
  logic [NREQ-1:0] ob_gnt1, ob_gnt_late, ob_done_val, ob_err_val;
  int              ob_done_cyc, ob_err_cyc, ob_done_n, ob_err_n, ob_wen_n, ob_ren_n, ob_busy_n;
  logic [DW-1:0]   ob_rdata, ob_rdata_end, ob_wdata;
  logic [AW-1:0]   ob_adrs;
  int              inj_w_len = 0;

  task automatic run_txn(input logic [NREQ-1:0] mask, input int ncyc);
    ob_gnt1 = '0; ob_gnt_late = '0; ob_done_val = '0; ob_err_val = '0;
    ob_done_cyc = -1; ob_err_cyc = -1; ob_done_n = 0; ob_err_n = 0;
    ob_wen_n = 0; ob_ren_n = 0; ob_busy_n = 0; ob_rdata = 'x;
    req = mask;
    inj_w = (inj_w_len > 0);
    for (int t = 1; t <= ncyc; t++) begin
      @(negedge clk);
      if (t == 1) ob_gnt1 = gnt; else ob_gnt_late |= gnt;
      if (mem_w_en) ob_wen_n++;
      if (mem_r_en) ob_ren_n++;
      if (busy) ob_busy_n++;
      if (done != '0) begin ob_done_n++; ob_done_cyc = t; ob_done_val = done; ob_rdata = rdata; end
      if (err != '0) begin ob_err_n++; ob_err_cyc = t; ob_err_val = err; end
      if (t == 1) req = '0;
      inj_w = (t < inj_w_len);
    end
    ob_adrs = mem_adrs;
    ob_wdata = mem_wdata;
    ob_rdata_end = rdata;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    ref_ptr = NREQ - 1;
    ref_rdata = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({gnt, done, err, rdata, busy, mem_adrs, mem_wdata, mem_w_en, mem_r_en} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt=%b done=%b err=%b rdata=%h busy=%b adrs=%h wdata=%h wen=%b ren=%b, all required 0",
               gnt, done, err, rdata, busy, mem_adrs, mem_wdata, mem_w_en, mem_r_en);
    end
    resetn = 1'b1;
    ref_ptr = NREQ - 1;
    ref_rdata = '0;
  endtask

  task automatic test_read_basic();
    poke_a = 11'h005; poke_d = 32'h00AB_CDEF; poke_en = 1'b1;
    @(negedge clk);
    poke_en = 1'b0;
    ref_mem[5] = 32'h00AB_CDEF;
    set_slot(2, 1'b0, 11'h005, $urandom);
    ref_ptr = rr_pick(ref_ptr, 4'b0100);
    run_txn(4'b0100, 4);
    n_tests++;
    if (ob_gnt1 !== 4'b0100) begin n_fail++; $display("FAIL basic_gnt: got %b want 0100", ob_gnt1); end
    n_tests++;
    if (ob_ren_n !== 1 || ob_wen_n !== 0) begin n_fail++; $display("FAIL basic_enables: r_en cycles %0d w_en cycles %0d, want 1/0", ob_ren_n, ob_wen_n); end
    n_tests++;
    if (ob_done_cyc !== 3 || ob_done_val !== 4'b0100 || ob_done_n !== 1) begin
      n_fail++; $display("FAIL basic_done: cycle %0d val %b count %0d, want 3/0100/1", ob_done_cyc, ob_done_val, ob_done_n);
    end
    n_tests++;
    if (ob_rdata !== 32'h00AB_CDEF) begin n_fail++; $display("FAIL basic_rdata: got %h want 00abcdef", ob_rdata); end
    n_tests++;
    if (ob_busy_n !== 2) begin n_fail++; $display("FAIL basic_busy: %0d cycles want 2", ob_busy_n); end
    ref_rdata = 32'h00AB_CDEF;
  endtask

  task automatic test_write_read();
    set_slot(1, 1'b1, 11'h7FF, 32'hDEAD_BEEF);
    ref_ptr = rr_pick(ref_ptr, 4'b0010);
    run_txn(4'b0010, 4);
    ref_mem[11'h7FF] = 32'hDEAD_BEEF;
    n_tests++;
    if (ob_wen_n !== 1 || ob_ren_n !== 0) begin n_fail++; $display("FAIL wr_enables: w_en cycles %0d r_en cycles %0d, want 1/0", ob_wen_n, ob_ren_n); end
    n_tests++;
    if (ob_done_cyc !== 3 || ob_done_val !== 4'b0010) begin n_fail++; $display("FAIL wr_done: cycle %0d val %b want 3/0010", ob_done_cyc, ob_done_val); end
    n_tests++;
    if (ob_rdata_end !== ref_rdata) begin n_fail++; $display("FAIL wr_rdata_hold: got %h want %h", ob_rdata_end, ref_rdata); end
    set_slot(1, 1'b0, 11'h7FF, $urandom);
    ref_ptr = rr_pick(ref_ptr, 4'b0010);
    run_txn(4'b0010, 4);
    n_tests++;
    if (ob_done_cyc !== 3 || ob_done_val !== 4'b0010 || ob_rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL rd_after_wr: cycle %0d val %b rdata %h, want 3/0010/deadbeef", ob_done_cyc, ob_done_val, ob_rdata);
    end
    ref_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic test_back_to_back();
    logic [NREQ-1:0] exp_g, exp_d;
    int last_w;
    do_reset();
    for (int k = 0; k < int'(NREQ); k++) set_slot(k, 1'b0, AW'($urandom_range(0, MSZ - 1)), $urandom);
    req = '1;
    last_w = -1;
    for (int t = 1; t <= 36; t++) begin
      @(negedge clk);
      exp_g = '0;
      exp_d = '0;
      if (t % 3 == 1) begin
        ref_ptr = rr_pick(ref_ptr, '1);
        exp_g = onehot(ref_ptr);
        last_w = ref_ptr;
      end
      if (t % 3 == 0) exp_d = onehot(last_w);
      n_tests++;
      if (gnt !== exp_g) begin n_fail++; $display("FAIL b2b_gnt cycle %0d: got %b want %b", t, gnt, exp_g); end
      n_tests++;
      if (done !== exp_d) begin n_fail++; $display("FAIL b2b_done cycle %0d: got %b want %b", t, done, exp_d); end
      if (t % 3 == 0) begin
        ref_rdata = ref_mem[adrs[last_w*AW +: AW]];
        n_tests++;
        if (rdata !== ref_rdata) begin n_fail++; $display("FAIL b2b_rdata cycle %0d: got %h want %h", t, rdata, ref_rdata); end
      end
    end
    req = '0;
  endtask

  task automatic test_timeout();
    int k;
    logic [AW-1:0] a;
    r_delay = 0;
    k = $urandom_range(0, NREQ - 1);
    set_slot(k, 1'b0, AW'($urandom_range(0, MSZ - 1)), $urandom);
    ref_ptr = rr_pick(ref_ptr, onehot(k));
    run_txn(onehot(k), TIMEOUT + 3);
    n_tests++;
    if (ob_gnt1 !== onehot(k)) begin n_fail++; $display("FAIL to_gnt: got %b want %b", ob_gnt1, onehot(k)); end
    n_tests++;
    if (ob_err_cyc !== int'(TIMEOUT) + 2 || ob_err_val !== onehot(k) || ob_err_n !== 1) begin
      n_fail++; $display("FAIL to_err: cycle %0d val %b count %0d, want %0d/%b/1", ob_err_cyc, ob_err_val, ob_err_n, TIMEOUT + 2, onehot(k));
    end
    n_tests++;
    if (ob_done_n !== 0) begin n_fail++; $display("FAIL to_no_done: %0d done pulses want 0", ob_done_n); end
    n_tests++;
    if (ob_rdata_end !== ref_rdata) begin n_fail++; $display("FAIL to_rdata_hold: got %h want %h", ob_rdata_end, ref_rdata); end
    n_tests++;
    if (ob_busy_n !== int'(TIMEOUT) + 1) begin n_fail++; $display("FAIL to_busy: %0d cycles want %0d", ob_busy_n, TIMEOUT + 1); end
    r_delay = 1;
    k = $urandom_range(0, NREQ - 1);
    a = AW'($urandom_range(0, MSZ - 1));
    set_slot(k, 1'b0, a, $urandom);
    ref_ptr = rr_pick(ref_ptr, onehot(k));
    ref_rdata = ref_mem[a];
    run_txn(onehot(k), 4);
    n_tests++;
    if (ob_done_cyc !== 3 || ob_done_val !== onehot(k) || ob_rdata !== ref_rdata) begin
      n_fail++; $display("FAIL to_recover: cycle %0d val %b rdata %h, want 3/%b/%h", ob_done_cyc, ob_done_val, ob_rdata, onehot(k), ref_rdata);
    end
  endtask

  task automatic test_spurious();
    int k;
    logic [AW-1:0] a;
    inj_data = ~ref_rdata;
    inj_r = 1'b1;
    @(negedge clk);
    inj_r = 1'b0;
    n_tests++;
    if (done !== '0 || rdata !== ref_rdata || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_r_valid: done %b rdata %h busy %b, want 0/%h/0", done, rdata, busy, ref_rdata);
    end
    r_delay = 4;
    inj_w_len = 5;
    k = 3;
    a = AW'($urandom_range(0, MSZ - 1));
    set_slot(k, 1'b0, a, $urandom);
    ref_ptr = rr_pick(ref_ptr, onehot(k));
    ref_rdata = ref_mem[a];
    run_txn(onehot(k), 7);
    inj_w_len = 0;
    r_delay = 1;
    n_tests++;
    if (ob_done_cyc !== 6 || ob_done_n !== 1 || ob_done_val !== onehot(k)) begin
      n_fail++; $display("FAIL spurious_w_valid: done cycle %0d count %0d val %b, want 6/1/%b", ob_done_cyc, ob_done_n, ob_done_val, onehot(k));
    end
    n_tests++;
    if (ob_rdata !== ref_rdata || ob_err_n !== 0 || ob_busy_n !== 5) begin
      n_fail++; $display("FAIL spurious_data: rdata %h err %0d busy %0d, want %h/0/5", ob_rdata, ob_err_n, ob_busy_n, ref_rdata);
    end
  endtask

  task automatic test_reset_in_wait();
    int k, n_done, n_err, done_at;
    logic [AW-1:0] a0;
    r_delay = 0;
    k = $urandom_range(0, NREQ - 1);
    set_slot(k, 1'b0, AW'($urandom_range(0, MSZ - 1)), $urandom);
    req = onehot(k);
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      if (t == 1) req = '0;
    end
    resetn = 1'b0;
    r_delay = 1;
    a0 = AW'($urandom_range(0, MSZ - 1));
    set_slot(0, 1'b0, a0, $urandom);
    for (int j = 1; j < int'(NREQ); j++) set_slot(j, 1'b0, AW'($urandom_range(0, MSZ - 1)), $urandom);
    req = '1;
    @(negedge clk);
    n_tests++;
    if ({gnt, done, err, rdata, busy, mem_adrs, mem_wdata, mem_w_en, mem_r_en} !== '0) begin
      n_fail++;
      $display("FAIL rst_wait_outputs: gnt=%b done=%b err=%b rdata=%h busy=%b adrs=%h wdata=%h wen=%b ren=%b, all required 0",
               gnt, done, err, rdata, busy, mem_adrs, mem_wdata, mem_w_en, mem_r_en);
    end
    resetn = 1'b1;
    ref_ptr = NREQ - 1;
    ref_rdata = '0;
    n_done = 0; n_err = 0; done_at = -1;
    for (int t = 6; t <= 16; t++) begin
      @(negedge clk);
      if (t == 6) begin
        ref_ptr = rr_pick(ref_ptr, '1);
        n_tests++;
        if (gnt !== onehot(ref_ptr)) begin n_fail++; $display("FAIL rst_wait_first_gnt: got %b want %b", gnt, onehot(ref_ptr)); end
        req = '0;
      end
      if (err !== '0) n_err++;
      if (done !== '0) begin
        n_done++;
        done_at = t;
        n_tests++;
        if (done !== 4'b0001 || rdata !== ref_mem[a0]) begin
          n_fail++; $display("FAIL rst_wait_done_val: done %b rdata %h, want 0001/%h", done, rdata, ref_mem[a0]);
        end
      end
    end
    ref_rdata = ref_mem[a0];
    n_tests++;
    if (n_err !== 0 || n_done !== 1 || done_at !== 8) begin
      n_fail++; $display("FAIL rst_wait_pulses: err %0d done %0d at cycle %0d, want 0/1/8", n_err, n_done, done_at);
    end
  endtask

  task automatic test_random(input int iters);
    logic [NREQ-1:0] mask;
    int w, idx;
    logic          exp_we;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    for (int it = 0; it < iters; it++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int k = 0; k < int'(NREQ); k++) begin
        idx = $urandom_range(0, 15);
        set_slot(k, 1'($urandom_range(0, 1)), AW'(idx < 8 ? idx : 2032 + idx), $urandom);
      end
      w = rr_pick(ref_ptr, mask);
      ref_ptr = w;
      exp_we = we[w];
      exp_a  = adrs[w*AW +: AW];
      exp_d  = wdata[w*DW +: DW];
      if (exp_we) ref_mem[exp_a] = exp_d;
      else ref_rdata = ref_mem[exp_a];
      run_txn(mask, 4);
      n_tests++;
      if (ob_gnt1 !== onehot(w) || ob_gnt_late !== '0) begin
        n_fail++; $display("FAIL rnd_gnt it %0d mask %b: got %b late %b want %b", it, mask, ob_gnt1, ob_gnt_late, onehot(w));
      end
      n_tests++;
      if (ob_wen_n !== int'(exp_we) || ob_ren_n !== int'(!exp_we)) begin
        n_fail++; $display("FAIL rnd_enables it %0d: w_en %0d r_en %0d, want we=%b", it, ob_wen_n, ob_ren_n, exp_we);
      end
      n_tests++;
      if (ob_done_cyc !== 3 || ob_done_n !== 1 || ob_done_val !== onehot(w) || ob_err_n !== 0) begin
        n_fail++; $display("FAIL rnd_done it %0d: cycle %0d count %0d val %b err %0d, want 3/1/%b/0", it, ob_done_cyc, ob_done_n, ob_done_val, ob_err_n, onehot(w));
      end
      n_tests++;
      if (ob_rdata !== ref_rdata || ob_rdata_end !== ref_rdata) begin
        n_fail++; $display("FAIL rnd_rdata it %0d: got %h/%h want %h", it, ob_rdata, ob_rdata_end, ref_rdata);
      end
      n_tests++;
      if (ob_adrs !== exp_a || ob_wdata !== exp_d) begin
        n_fail++; $display("FAIL rnd_hold it %0d: adrs %h wdata %h, want %h/%h", it, ob_adrs, ob_wdata, exp_a, exp_d);
      end
      n_tests++;
      if (ob_busy_n !== 2) begin n_fail++; $display("FAIL rnd_busy it %0d: %0d cycles want 2", it, ob_busy_n); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < int'(MSZ); a++) ref_mem[a] = seed_word(a);
    resetn = 1'b0;
    req = '0; we = '0; adrs = '0; wdata = '0;
    @(negedge clk);
    test_reset();
    test_read_basic();
    test_write_read();
    test_back_to_back();
    test_timeout();
    test_spurious();
    test_reset_in_wait();
    test_random(60);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
